// File: rtl/hazard_stall_controller.sv
// Stall/bubble/freeze sequencer for the 5-stage MIPS pipeline.
// It covers load-use, branch-in-ID operand hazards and multi-cycle data-memory waits, and keeps saturating counters.
module hazard_stall_controller #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IF_ID_Rs,
  input  logic [4:0]       IF_ID_Rt,
  input  logic             ID_uses_rt,
  input  logic             ID_is_branch,
  input  logic             ID_branch_taken,
  input  logic             ID_is_jump,
  input  logic [4:0]       ID_EX_Rd,
  input  logic             ID_EX_MemRead,
  input  logic             ID_EX_RegWrite,
  input  logic [4:0]       EX_MEM_Rd,
  input  logic             EX_MEM_MemRead,
  input  logic             EX_MEM_MemWrite,
  input  logic             mem_ready,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             ID_EX_write,
  output logic             EX_MEM_write,
  output logic             MEM_WB_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN = 2'd0, STALL2 = 2'd1, MEMWAIT = 2'd2} state_t;
  typedef enum logic [1:0] {O_NORMAL = 2'd0, O_STALL = 2'd1, O_FLUSH = 2'd2, O_FREEZE = 2'd3} oset_t;

  state_t state, state_nxt, run_nxt;
  oset_t  oset, run_oset;
  logic   ret_stall2, ret_stall2_nxt;

  logic m_ex, m_mem, mem_busy, lu, br_ex, br_mem, need_stall, need_stall2, redirect;

  // Operand-match terms; $0 is never a dependency.
  assign m_ex  = (ID_EX_Rd != 5'd0) &&
                 ((ID_EX_Rd == IF_ID_Rs) || (ID_uses_rt && (ID_EX_Rd == IF_ID_Rt)));
  assign m_mem = (EX_MEM_Rd != 5'd0) &&
                 ((EX_MEM_Rd == IF_ID_Rs) || (ID_uses_rt && (EX_MEM_Rd == IF_ID_Rt)));

  assign mem_busy    = (EX_MEM_MemRead | EX_MEM_MemWrite) & ~mem_ready;
  assign lu          = ID_EX_MemRead & m_ex;
  assign br_ex       = ID_is_branch & ID_EX_RegWrite & ~ID_EX_MemRead & m_ex;
  assign br_mem      = ID_is_branch & EX_MEM_MemRead & m_mem;
  assign need_stall  = lu | br_ex | br_mem;
  assign need_stall2 = lu & ID_is_branch;
  assign redirect    = ID_is_jump | (ID_is_branch & ID_branch_taken);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      ret_stall2 <= 1'b0;
    end else begin
      state      <= state_nxt;
      ret_stall2 <= ret_stall2_nxt;
    end
  end

  // RUN evaluation with the memory term excluded; shared by RUN and MEMWAIT resume.
  always_comb begin
    run_oset = O_NORMAL;
    run_nxt  = RUN;
    if (need_stall) begin
      run_oset = O_STALL;
      if (need_stall2) run_nxt = STALL2;
    end else if (redirect) begin
      run_oset = O_FLUSH;
    end
  end

  always_comb begin
    state_nxt      = state;
    ret_stall2_nxt = ret_stall2;
    oset           = O_NORMAL;
    unique case (state)
      RUN: begin
        if (mem_busy) begin
          oset           = O_FREEZE;
          ret_stall2_nxt = 1'b0;
          state_nxt      = MEMWAIT;
        end else begin
          oset      = run_oset;
          state_nxt = run_nxt;
        end
      end
      STALL2: begin
        if (mem_busy) begin
          oset           = O_FREEZE;
          ret_stall2_nxt = 1'b1;
          state_nxt      = MEMWAIT;
        end else begin
          oset      = O_STALL;
          state_nxt = RUN;
        end
      end
      MEMWAIT: begin
        if (!mem_ready) begin
          oset = O_FREEZE;
        end else if (ret_stall2) begin
          oset      = O_STALL;
          state_nxt = RUN;
        end else begin
          oset      = run_oset;
          state_nxt = run_nxt;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // Decode the selected output set; everything is held off during reset.
  always_comb begin
    PC_write     = 1'b0;
    IF_ID_write  = 1'b0;
    ID_EX_write  = 1'b0;
    EX_MEM_write = 1'b0;
    MEM_WB_write = 1'b0;
    IF_ID_flush  = 1'b0;
    ID_EX_flush  = 1'b0;
    if (!rst) begin
      unique case (oset)
        O_NORMAL, O_FLUSH: begin
          PC_write     = 1'b1;
          IF_ID_write  = 1'b1;
          ID_EX_write  = 1'b1;
          EX_MEM_write = 1'b1;
          MEM_WB_write = 1'b1;
          IF_ID_flush  = (oset == O_FLUSH);
        end
        O_STALL: begin
          ID_EX_write  = 1'b1;
          EX_MEM_write = 1'b1;
          MEM_WB_write = 1'b1;
          ID_EX_flush  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!PC_write && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (IF_ID_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/hazard_stall_controller.md
# hazard_stall_controller

Sequences pipeline stalls, bubbles and freezes for the 5-stage MIPS pipeline. It sits beside the EX and ID forwarding units and covers the cases forwarding cannot resolve: load-use, branch-in-ID operand dependencies, and multi-cycle data-memory access. It drives the stage-register write enables and flushes, and keeps saturating stall and flush performance counters.

## Interface
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk` in 1: pipeline clock.
- `rst` in 1: asynchronous, active-high reset.
- `IF_ID_Rs`, `IF_ID_Rt` in 5 each: source registers of the instruction in ID.
- `ID_uses_rt` in 1: the ID instruction reads Rt (R-type, beq, sw).
- `ID_is_branch` in 1: the ID instruction is beq, compared in ID.
- `ID_branch_taken` in 1: the ID comparator result, valid when `ID_is_branch`.
- `ID_is_jump` in 1: the ID instruction is j.
- `ID_EX_Rd` in 5: write destination of the EX instruction.
- `ID_EX_MemRead`, `ID_EX_RegWrite` in 1 each.
- `EX_MEM_Rd` in 5; `EX_MEM_MemRead`, `EX_MEM_MemWrite` in 1 each.
- `mem_ready` in 1: data memory has completed the access this cycle.
- `PC_write`, `IF_ID_write`, `ID_EX_write`, `EX_MEM_write`, `MEM_WB_write` out 1 each: stage-register enables.
- `IF_ID_flush`, `ID_EX_flush` out 1 each: insert a bubble.
- `stall_cnt`, `flush_cnt` out `CNT_W` each: performance counters.

## Operation
Hazard terms are combinational. `m(r)` means `r != 0 && (r == IF_ID_Rs || (ID_uses_rt && r == IF_ID_Rt))`.

- `mem_busy` = `(EX_MEM_MemRead | EX_MEM_MemWrite) & ~mem_ready`.
- `lu` = `ID_EX_MemRead & m(ID_EX_Rd)`. Stall length 1; length 2 if `ID_is_branch`.
- `br_ex` = `ID_is_branch & ID_EX_RegWrite & ~ID_EX_MemRead & m(ID_EX_Rd)`. Stall length 1.
- `br_mem` = `ID_is_branch & EX_MEM_MemRead & m(EX_MEM_Rd)`. Stall length 1.
- N = the maximum of the applicable stall lengths (0, 1 or 2).

Output sets:
- FREEZE: all five write enables 0, both flushes 0.
- STALL: `PC_write`=0, `IF_ID_write`=0, `ID_EX_flush`=1; other enables 1.
- FLUSH: all enables 1, `IF_ID_flush`=1.
- NORMAL: all enables 1, both flushes 0.

FSM states are RUN, STALL2 and MEMWAIT. Registers: state, `ret_state` (1 bit: RUN or STALL2), and the counters.

- RUN, evaluated in priority order:
  - `mem_busy`: FREEZE; `ret_state`<=RUN; go to MEMWAIT.
  - N>0: STALL; if N==2 go to STALL2, else stay in RUN.
  - `ID_is_jump | (ID_is_branch & ID_branch_taken)`: FLUSH.
  - Otherwise NORMAL.
- STALL2:
  - `mem_busy`: FREEZE; `ret_state`<=STALL2; go to MEMWAIT.
  - Otherwise STALL; go to RUN. No re-evaluation of hazards; exactly one extra bubble.
- MEMWAIT:
  - `mem_ready`=0: FREEZE.
  - `mem_ready`=1: outputs equal those of `ret_state` evaluated this cycle (Mealy), with `mem_busy` treated as 0. Next state is the one `ret_state` would select.
- Counters:
  - `stall_cnt`+1 on every non-reset cycle with `PC_write`=0.
  - `flush_cnt`+1 on every cycle with `IF_ID_flush`=1.
  - Both saturate at all-ones and never wrap.

## Timing
- Reset (`rst`=1, asynchronous): state=RUN, `ret_state`=RUN, counters=0. While `rst` is high, all enables are 0 and both flushes are 0. The first cycle after release evaluates as RUN.
- Reset mid-STALL2 or mid-MEMWAIT aborts immediately to RUN; no pending bubble survives.
- Outputs are combinational and act in the same cycle. State and counters update on the rising edge of `clk`.
- Stall latency:
  - load followed by a dependent ALU op: 1 bubble.
  - load followed by a dependent beq: 2 bubbles.
  - ALU op followed by a dependent beq: 1 bubble.
- MEMWAIT preserves STALL2's pending bubble. A memory wait overlapping a branch-load stall adds its own cycles; it does not replace the stall.
- A hazard has priority over a taken branch. The branch resolves, and flushes, on the first non-stall cycle.
- Register $0 never causes a stall.

## Test plan
1. `lw $2,0($0)`; `add $3,$2,$4` -> one cycle with `PC_write`=0 and `ID_EX_flush`=1, then NORMAL; `stall_cnt`=1.
2. `lw $2`; `beq $2,$5` taken -> two STALL cycles (RUN then STALL2), then one FLUSH cycle; `stall_cnt`=2, `flush_cnt`=1.
3. `add $2`; `beq $2,$0`, with `mem_ready` held low for 3 cycles while a `sw` sits in EX/MEM -> 3 FREEZE cycles, then the STALL sequence resumes; no lost or duplicated bubble.
4. `lw $0`; `add $3,$0,$0` -> no stall; `stall_cnt` stays 0.
5. `rst` pulsed mid-STALL2 -> all enables 0 asynchronously; after release, RUN with counters=0.
6. Force `stall_cnt` to all-ones (`CNT_W`=4: 15) and add one more stall -> it stays 15.
